// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
// Queue entries carry a destination register and its result.
package regfile_wb_ctrl_pkg;

    localparam int WB_AW = 5;
    localparam int WB_DW = 32;

    localparam logic [WB_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    // r0 is hard-wired zero, so it is never written or forwarded
    function automatic logic addr_live(input logic [WB_AW-1:0] a);
        return a != REG_ZERO;
    endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// In-order writeback queue: up to two pushes and one pop per cycle.
// Entries are exposed oldest-first (index 0 = head) for the forwarding search.
module regfile_wb_fifo
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0_i,
    input  wb_entry_t        push0_ent_i,
    input  logic             push1_i,
    input  wb_entry_t        push1_ent_i,
    input  logic             pop_i,
    output logic [CW-1:0]    count_o,
    output wb_entry_t        ent_o [DEPTH],
    output logic [DEPTH-1:0] vld_o
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    n_push_s;
    logic [PW-1:0] wr_ptr_nx_s;

    // Next-state: push0 is older and lands first; push1 follows it
    always_comb begin
        mem_d       = mem_q;
        n_push_s    = {1'b0, push0_i} + {1'b0, push1_i};
        wr_ptr_nx_s = wr_ptr_q + PW'(1);
        if (push0_i) begin
            mem_d[wr_ptr_q] = push0_ent_i;
        end else begin
            mem_d[wr_ptr_q] = mem_d[wr_ptr_q];
        end
        if (push1_i) begin
            mem_d[push0_i ? wr_ptr_nx_s : wr_ptr_q] = push1_ent_i;
        end else begin
            mem_d[wr_ptr_q] = mem_d[wr_ptr_q];
        end
        wr_ptr_d = wr_ptr_q + PW'(n_push_s);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(n_push_s) - CW'(pop_i);
    end

    // Queue state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Age-ordered view of the queue
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_o[i] = mem_q[rd_ptr_q + PW'(i)];
            vld_o[i] = CW'(i) < count_q;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: merges load and ALU results into one register-file
// write per cycle, with youngest-match forwarding for two decode reads.
module regfile_wb_ctrl
    import regfile_wb_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [AW-1:0]              mem_addr,
    input  logic [DW-1:0]              mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [AW-1:0]              alu_addr,
    input  logic [DW-1:0]              alu_data,
    input  logic                       wr_hold,
    output logic                       wr_en,
    output logic [AW-1:0]              wr_addr,
    output logic [DW-1:0]              wr_data,
    input  logic [AW-1:0]              fwd1_addr,
    input  logic [AW-1:0]              fwd2_addr,
    output logic                       fwd1_hit,
    output logic                       fwd2_hit,
    output logic [DW-1:0]              fwd1_data,
    output logic [DW-1:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       pending
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count_s;
    logic [CW-1:0]    free_s;
    wb_entry_t        ent_s [DEPTH];
    logic [DEPTH-1:0] vld_s;
    logic             push_mem_s, push_alu_s, pop_s;
    wb_entry_t        mem_ent_s, alu_ent_s;

    logic             wr_en_q,   wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0]    wr_data_q, wr_data_d;

    logic [AW-1:0]    fwd_addr_s [2];
    logic [1:0]       fwd_hit_s;
    logic [DW-1:0]    fwd_data_s [2];

    // Readies look only at the registered count; a same-cycle pop earns no credit
    always_comb begin
        free_s    = CW'(DEPTH) - count_s;
        mem_ready = free_s >= CW'(1);
        if (mem_valid) begin
            alu_ready = free_s >= CW'(2);
        end else begin
            alu_ready = free_s >= CW'(1);
        end
        mem_ent_s  = '{addr: mem_addr, data: mem_data};
        alu_ent_s  = '{addr: alu_addr, data: alu_data};
        push_mem_s = mem_valid && mem_ready && addr_live(mem_addr);
        push_alu_s = alu_valid && alu_ready && addr_live(alu_addr);
        pop_s      = (count_s != CW'(0)) && !wr_hold;
    end

    regfile_wb_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push0_i     (push_mem_s),
        .push0_ent_i (mem_ent_s),
        .push1_i     (push_alu_s),
        .push1_ent_i (alu_ent_s),
        .pop_i       (pop_s),
        .count_o     (count_s),
        .ent_o       (ent_s),
        .vld_o       (vld_s)
    );

    // Output stage: address/data hold their last value when idle
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pop_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ent_s[0].addr;
            wr_data_d = ent_s[0].data;
        end else begin
            wr_en_d   = 1'b0;
        end
    end

    // Register-file write port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Forwarding: output register is oldest, then queue head to tail; later matches win
    always_comb begin
        fwd_addr_s[0] = fwd1_addr;
        fwd_addr_s[1] = fwd2_addr;
        for (int k = 0; k < 2; k++) begin
            fwd_hit_s[k]  = 1'b0;
            fwd_data_s[k] = '0;
            if (addr_live(fwd_addr_s[k])) begin
                if (wr_en_q && (wr_addr_q == fwd_addr_s[k])) begin
                    fwd_hit_s[k]  = 1'b1;
                    fwd_data_s[k] = wr_data_q;
                end else begin
                    fwd_hit_s[k]  = 1'b0;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    if (vld_s[i] && (ent_s[i].addr == fwd_addr_s[k])) begin
                        fwd_hit_s[k]  = 1'b1;
                        fwd_data_s[k] = ent_s[i].data;
                    end else begin
                        fwd_hit_s[k]  = fwd_hit_s[k];
                    end
                end
            end else begin
                fwd_hit_s[k] = 1'b0;
            end
        end
    end

    assign fwd1_hit  = fwd_hit_s[0];
    assign fwd2_hit  = fwd_hit_s[1];
    assign fwd1_data = fwd_data_s[0];
    assign fwd2_data = fwd_data_s[1];
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign count     = count_s;
    assign pending   = (count_s != CW'(0)) || wr_en_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized + directed bench for regfile_wb_ctrl against a queue-based reference model.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, alu_valid, alu_ready, wr_hold;
    logic [4:0]  mem_addr, alu_addr, fwd1_addr, fwd2_addr, wr_addr;
    logic [31:0] mem_data, alu_data, wr_data, fwd1_data, fwd2_data;
    logic        wr_en, fwd1_hit, fwd2_hit, pending;
    logic [2:0]  count;

    regfile_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .wr_hold(wr_hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .fwd1_addr(fwd1_addr), .fwd2_addr(fwd2_addr),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    // Reference model: results waiting to be written, plus the write in flight
    wr_t         mq[$];
    bit          out_v;
    logic [4:0]  last_a;
    logic [31:0] last_d;
    logic [31:0] rf [32];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Youngest pending value for an address: newest queued result, else the in-flight write
    function automatic bit model_fwd(input logic [4:0] a, output logic [31:0] d);
        d = 32'd0;
        if (a == 5'd0) return 1'b0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].a == a) begin
                d = mq[i].d;
                return 1'b1;
            end
        end
        if (out_v && last_a == a) begin
            d = last_d;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock cycle, entered and left just after a falling edge
    task automatic step(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                        input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit hold, input logic [4:0] f1, input logic [4:0] f2);
        int          free;
        bit          mr, ar, h;
        logic [31:0] fd;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        wr_hold = hold; fwd1_addr = f1; fwd2_addr = f2;
        #1;
        free = DEPTH - mq.size();
        mr = free >= 1;
        ar = mv ? (free >= 2) : (free >= 1);
        check("mem_ready", {31'd0, mem_ready}, {31'd0, mr});
        check("alu_ready", {31'd0, alu_ready}, {31'd0, ar});
        h = model_fwd(f1, fd);
        check("fwd1_hit", {31'd0, fwd1_hit}, {31'd0, h});
        check("fwd1_data", fwd1_data, fd);
        h = model_fwd(f2, fd);
        check("fwd2_hit", {31'd0, fwd2_hit}, {31'd0, h});
        check("fwd2_data", fwd2_data, fd);
        @(posedge clk);
        if (mq.size() != 0 && !hold) begin
            wr_t e;
            e = mq.pop_front();
            out_v = 1'b1; last_a = e.a; last_d = e.d;
        end else begin
            out_v = 1'b0;
        end
        if (mv && mr && ma != 5'd0) mq.push_back('{a: ma, d: md});
        if (av && ar && aa != 5'd0) mq.push_back('{a: aa, d: ad});
        @(negedge clk);
        if (wr_en) rf[wr_addr] = wr_data;
        check("wr_en", {31'd0, wr_en}, {31'd0, out_v});
        check("wr_addr", {27'd0, wr_addr}, {27'd0, last_a});
        check("wr_data", wr_data, last_d);
        check("count", {29'd0, count}, 32'(mq.size()));
        check("pending", {31'd0, pending}, {31'd0, (mq.size() != 0) || out_v});
    endtask

    task automatic idle(input int n, input logic [4:0] f1);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, f1, 5'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        out_v = 1'b0; last_a = 5'd0; last_d = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        mem_valid = 0; alu_valid = 0; wr_hold = 0;
        mem_addr = 5'd0; alu_addr = 5'd0; mem_data = 32'd0; alu_data = 32'd0;
        fwd1_addr = 5'd0; fwd2_addr = 5'd0;
        model_reset();
        rst = 1'b1;
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Dual acceptance on empty queue: mem older than alu
        step(1, 5'd2, 32'd8, 1, 5'd3, 32'd5, 0, 5'd2, 5'd3);
        check("dual_cnt2", {29'd0, count}, 32'd2);
        idle(1, 5'd0);
        check("dual_w1_addr", {27'd0, wr_addr}, 32'd2);
        check("dual_w1_data", wr_data, 32'd8);
        check("dual_cnt1", {29'd0, count}, 32'd1);
        idle(1, 5'd0);
        check("dual_w2_addr", {27'd0, wr_addr}, 32'd3);
        check("dual_w2_data", wr_data, 32'd5);
        check("dual_cnt0", {29'd0, count}, 32'd0);
        idle(1, 5'd0);

        // Same-address back-to-back: later value forwarded, then committed
        step(0, 5'd0, 32'd0, 1, 5'd4, 32'hAAAA, 0, 5'd4, 5'd4);
        step(0, 5'd0, 32'd0, 1, 5'd4, 32'h5555, 0, 5'd4, 5'd4);
        check("b2b_fwd", fwd1_data, 32'h5555);
        idle(3, 5'd4);
        check("b2b_rf", rf[4], 32'h5555);
        check("b2b_nohit", {31'd0, fwd1_hit}, 32'd0);

        // Hold: fill to DEPTH, then stall alu at count DEPTH-1 with mem valid
        step(1, 5'd5, 32'd1, 1, 5'd6, 32'd2, 1, 5'd5, 5'd6);
        step(1, 5'd7, 32'd3, 1, 5'd8, 32'd4, 1, 5'd7, 5'd8);
        check("hold_cnt4", {29'd0, count}, 32'd4);
        step(1, 5'd9, 32'd9, 1, 5'd10, 32'd10, 1, 5'd9, 5'd10);
        idle(1, 5'd5);
        check("hold_cnt3", {29'd0, count}, 32'd3);
        step(1, 5'd11, 32'd11, 1, 5'd12, 32'd12, 1, 5'd11, 5'd12);
        check("hold_cnt_after", {29'd0, count}, 32'd4);
        idle(6, 5'd11);

        // r0 write: handshake completes, nothing queued or forwarded
        step(0, 5'd0, 32'd0, 1, 5'd0, 32'd7, 0, 5'd0, 5'd0);
        check("r0_cnt", {29'd0, count}, 32'd0);
        idle(2, 5'd0);

        // Reset with three entries queued
        step(1, 5'd13, 32'd13, 1, 5'd14, 32'd14, 1, 5'd13, 5'd14);
        step(1, 5'd15, 32'd15, 0, 5'd0, 32'd0, 1, 5'd13, 5'd14);
        mem_valid = 0; alu_valid = 0; fwd1_addr = 5'd13;
        rst = 1'b1;
        #1;
        check("mrst_wr_en", {31'd0, wr_en}, 32'd0);
        check("mrst_count", {29'd0, count}, 32'd0);
        check("mrst_fwd1_hit", {31'd0, fwd1_hit}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle(4, 5'd13);

        // Random dual-source traffic with random hold
        for (int c = 0; c < 10000; c++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 3) == 0),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(8, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Writeback controller driving the write port of the 32 x 32-bit register file. Accepts results from the ALU and memory-load paths through valid/ready handshakes, buffers them in a small in-order queue, and issues exactly one register-file write per cycle. Provides youngest-match forwarding for two decode-stage read addresses, so data not yet committed to the register file is never read stale.

## Interface
- DEPTH, 4, queue entries (power of two, >= 2)
- AW, 5, register address width
- DW, 32, data width

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_valid  in  1  load result valid
- mem_ready  out  1  load result accepted this cycle
- mem_addr  in  AW  destination register
- mem_data  in  DW  load result
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted this cycle
- alu_addr  in  AW  destination register
- alu_data  in  DW  ALU result
- wr_hold  in  1  1 = do not drain this cycle (port borrowed by debug/test)
- wr_en  out  1  register-file write enable (registered)
- wr_addr  out  AW  register-file write address (registered)
- wr_data  out  DW  register-file write data (registered)
- fwd1_addr, fwd2_addr  in  AW  decode read addresses
- fwd1_hit, fwd2_hit  out  1  pending write to that address exists
- fwd1_data, fwd2_data  out  DW  youngest pending data for that address
- count  out  $clog2(DEPTH)+1  occupied queue entries
- pending  out  1  count != 0 or wr_en == 1

## Operation
- free = DEPTH - count (registered value; no credit for same-cycle pop).
- mem_ready = (free >= 1); alu_ready = mem_valid ? (free >= 2) : (free >= 1). Readies are combinational from count and mem_valid only.
- Both sources may be accepted in one cycle. Ordering: mem entry enqueued first (older), then alu.
- Accepted results with addr == 0 complete the handshake but are not enqueued (r0 is never written).
- Drain: if count != 0 and wr_hold == 0, pop head into output register: wr_en=1, wr_addr/wr_data = head. Otherwise wr_en=0; wr_addr/wr_data hold previous values.
- Push and pop in the same cycle are allowed; count updates by (pushes - pop).
- Forwarding (combinational): search output register (if wr_en) and all valid queue entries; youngest match wins (queue tail over head, queue over output register). Address 0 never hits; on miss, hit=0 and data=0.
- Overflow is impossible by construction; a push with ready low is a protocol violation of the source and is ignored.

## Timing
- Reset (async assert): count=0, pointers=0, wr_en=0, wr_addr=0, wr_data=0; fwd hits 0; pending 0. Mid-operation reset discards all queued writes.
- Latency: result accepted at edge N is head-of-empty queue -> wr_en high from edge N+1 to N+2; register file commits at the falling edge inside that cycle.
- Forwarding covers the entry from acceptance edge through the end of its wr_en cycle, so the falling-edge commit closes the window with no gap.
- wr_hold asserted: queue fills; readies drop at count == DEPTH (mem) / DEPTH-1 with mem_valid (alu).
- Two writes to the same address stay in order; the later is forwarded.

## Structure
- Shared package: AW/DW defaults, REG_ZERO constant (5'd0), queue entry struct {addr, data}.
- One sub-module: regfile_wb_fifo (DEPTH-entry, dual-push/single-pop queue exposing all entries and valid bits for the forwarding search). Forwarding mux and handshake logic live in the top.

## Test plan
- Reset mid-stream with 3 entries queued -> wr_en=0, count=0, fwd1_hit=0 immediately, no later writes.
- mem (r2, 8) and alu (r3, 5) valid same cycle on empty queue -> both accepted; writes r2=8 then r3=5 on consecutive cycles; count 2,1,0.
- alu writes r4=0xAAAA then r4=0x5555 back-to-back, fwd1_addr=4 -> fwd1_data=0x5555 until second write's wr_en cycle ends; register file reads 0x5555 after.
- wr_hold=1, push 4 entries -> count=4, mem_ready=0, alu_ready=0; with count=3 and both valid, mem accepted, alu stalled.
- alu write to r0 with value 7 -> alu_ready=1, count unchanged, wr_en never high, fwd hit on r0 = 0.
- Random dual-source traffic with random wr_hold, 10k cycles -> written sequence equals reference model order; forwarded data always equals model's latest value.
